tpu_requant_drain: RTL and testbench

Output stage directly downstream of the matrix-multiply core. After the core has written its 4×4 int32 accumulator tile into the C buffer, this block reads the tile one row at a time. For each row it adds a per-column bias and applies TFLite-style fixed-point requantization (multiplier, shift, output offset, activation clamp). It then returns each row to the CPU/CFU side as one packed 32-bit word of four int8 values, using a valid/ready handshake.

---
 rtl/tpu_requant_drain_if.sv | 10 +
 rtl/tpu_requant_drain.sv | 172 +++++++++++++++++
 tb/tb_tpu_requant_drain.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_requant_drain_if.sv
// Packed int8 result stream from the requant drain towards the CPU/CFU side.
// One 32-bit word per tile row, valid/ready handshake.
interface tpu_requant_drain_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/tpu_requant_drain.sv
// Drains the int32 accumulator tile row by row: bias add, TFLite fixed-point
// requantization and activation clamp, then one packed int8 word per row.
module tpu_requant_drain #(
  parameter int ROWS_MAX = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic [2:0]                  rows_i,
  input  logic [127:0]                bias_i,
  input  logic [31:0]                 multiplier_i,
  input  logic [5:0]                  shift_i,
  input  logic [31:0]                 out_offset_i,
  input  logic [7:0]                  act_min_i,
  input  logic [7:0]                  act_max_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [$clog2(ROWS_MAX)-1:0] C_index_o,
  input  logic [127:0]                C_data_out_i,
  tpu_requant_drain_if.master         out_if
);
  localparam int IW = $clog2(ROWS_MAX);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] P1   = 3'd2;
  localparam logic [2:0] P2   = 3'd3;
  localparam logic [2:0] P3   = 3'd4;
  localparam logic [2:0] OUT  = 3'd5;
  localparam logic [2:0] DONE = 3'd6;

  localparam logic signed [31:0] INT_MIN   = 32'sh8000_0000;
  localparam logic signed [31:0] INT_MAX   = 32'sh7fff_ffff;
  localparam logic signed [63:0] NUDGE_POS = 64'sd1073741824;
  localparam logic signed [63:0] NUDGE_NEG = -64'sd1073741823;
  localparam logic signed [63:0] TRUNC_ADJ = 64'sd2147483647;

  logic [2:0]          state_q, state_d;
  logic                busy_q, done_q, valid_q;
  logic [31:0]         data_q;
  logic [IW-1:0]       C_index_q;
  logic [2:0]          row_q, rows_q;
  logic [127:0]        bias_q;
  logic signed [31:0]  mult_q, offset_q;
  logic [5:0]          shift_q;
  logic [7:0]          act_min_q, act_max_q;

  logic [2:0]          rows_clamped;
  logic                accept, handshake, last_row, shift_left;
  logic [5:0]          e_amt;
  logic [63:0]         round_mask;
  logic [31:0]         res_word;

  assign rows_clamped = (rows_i > 3'(ROWS_MAX)) ? 3'(ROWS_MAX) : rows_i;
  assign accept       = (state_q == IDLE) && start_i;
  assign handshake    = (state_q == OUT) && out_if.out_ready;
  assign last_row     = (row_q == rows_q - 3'd1);
  assign shift_left   = !shift_q[5] && (shift_q != 6'd0);
  // Negative shift selects a rounding right shift of up to 32 bits.
  assign e_amt        = shift_q[5] ? (6'd0 - shift_q) : 6'd0;
  assign round_mask   = (64'd1 << e_amt) - 64'd1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (rows_clamped == 3'd0) ? DONE : RD;
      RD:      state_d = P1;
      P1:      state_d = P2;
      P2:      state_d = P3;
      P3:      state_d = OUT;
      OUT:     if (out_if.out_ready) state_d = last_row ? DONE : RD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      C_index_q <= '0;
      row_q     <= '0;
      rows_q    <= '0;
      bias_q    <= '0;
      mult_q    <= '0;
      shift_q   <= '0;
      offset_q  <= '0;
      act_min_q <= '0;
      act_max_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == DONE);
      if (accept) begin
        rows_q    <= rows_clamped;
        bias_q    <= bias_i;
        mult_q    <= multiplier_i;
        shift_q   <= shift_i;
        offset_q  <= out_offset_i;
        act_min_q <= act_min_i;
        act_max_q <= act_max_i;
        row_q     <= '0;
        busy_q    <= 1'b1;
        if (rows_clamped != 3'd0) C_index_q <= '0;
      end else if (state_q == DONE) begin
        busy_q <= 1'b0;
      end
      if (state_q == P3) begin
        valid_q <= 1'b1;
        data_q  <= res_word;
      end else if (handshake) begin
        valid_q <= 1'b0;
        if (!last_row) begin
          row_q     <= row_q + 3'd1;
          C_index_q <= IW'(row_q + 3'd1);
        end
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic signed [31:0] acc, bsum, x_d, x_q, h, r_rnd, y, lo, hi, y_clamped;
    logic signed [63:0] x_ext, m_ext, p_d, p_q, p_nudged, p_adj, h_ext, r_full;
    logic [63:0]        rem, thr;
    logic               round_up, unused_bits;

    assign acc   = C_data_out_i[32*gi +: 32];
    assign bsum  = acc + $signed(bias_q[32*gi +: 32]);
    assign x_d   = shift_left ? (bsum << shift_q[4:0]) : bsum;
    assign x_ext = x_q;
    assign m_ext = mult_q;
    assign p_d   = x_ext * m_ext;

    // Doubling high multiply: nudge, then divide by 2^31 rounding toward zero.
    assign p_nudged = p_q + (p_q[63] ? NUDGE_NEG : NUDGE_POS);
    assign p_adj    = p_nudged[63] ? (p_nudged + TRUNC_ADJ) : p_nudged;
    assign h        = ((x_q == INT_MIN) && (mult_q == INT_MIN)) ? INT_MAX : p_adj[62:31];

    assign h_ext    = h;
    assign rem      = h_ext & round_mask;
    assign thr      = (round_mask >> 1) + {63'd0, h[31]};
    assign round_up = (rem > thr);
    assign r_full   = h_ext >>> e_amt;
    assign r_rnd    = r_full[31:0] + {31'd0, round_up};
    assign y        = r_rnd + offset_q;

    assign lo        = {{24{act_min_q[7]}}, act_min_q};
    assign hi        = {{24{act_max_q[7]}}, act_max_q};
    assign y_clamped = (y < lo) ? lo : ((y > hi) ? hi : y);
    assign res_word[8*gi +: 8] = y_clamped[7:0];

    assign unused_bits = ^{p_adj[63], p_adj[30:0], r_full[63:32], y_clamped[31:8]};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        x_q <= '0;
        p_q <= '0;
      end else begin
        if (state_q == P1) x_q <= x_d;
        if (state_q == P2) p_q <= p_d;
      end
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign C_index_o        = C_index_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
endmodule

// File: tb/tb_tpu_requant_drain.sv
// Directed bench for tpu_requant_drain: C buffer model, arithmetic reference
// model with a result queue, and one negedge monitor checking every valid cycle.
`timescale 1ns/1ps
module tb_tpu_requant_drain;
  localparam int INT_MIN = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic [2:0]   rows_i = '0;
  logic [127:0] bias_i = '0;
  logic [31:0]  multiplier_i = '0;
  logic [5:0]   shift_i = '0;
  logic [31:0]  out_offset_i = '0;
  logic [7:0]   act_min_i = '0;
  logic [7:0]   act_max_i = '0;
  logic         busy_o, done_o;
  logic [1:0]   C_index_o;
  logic [127:0] C_data_out_i = '0;
  logic         out_ready = 1'b1;

  tpu_requant_drain_if o_if();
  assign o_if.out_ready = out_ready;

  tpu_requant_drain #(.ROWS_MAX(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .rows_i       (rows_i),
    .bias_i       (bias_i),
    .multiplier_i (multiplier_i),
    .shift_i      (shift_i),
    .out_offset_i (out_offset_i),
    .act_min_i    (act_min_i),
    .act_max_i    (act_max_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .C_index_o    (C_index_o),
    .C_data_out_i (C_data_out_i),
    .out_if       (o_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // C buffer with synchronous read.
  logic [127:0] cbuf [4];
  always @(posedge clk) C_data_out_i <= cbuf[C_index_o];

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q [$];
  int idx_log [$];
  int t_start = -1;
  int words_seen, done_cnt, first_valid_rel, done_rel, busy_fall_rel, stall_seen;
  int stall_row = 0;
  int stall_left = 0;
  bit hs_prev = 0;
  bit busy_prev = 0;
  logic [31:0] last_word = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: round-half-away-from-zero of the doubled high product.
  function automatic logic [7:0] ref_byte(input int acc, input int b, input int m, input int sh,
                                          input int off, input int amin, input int amax);
    int x, e, y;
    longint p, h, mag, r;
    x = acc + b;
    if (sh > 0) x = x << sh;
    p = longint'(x) * longint'(m);
    if (x == INT_MIN && m == INT_MIN) h = 64'sd2147483647;
    else h = (p + ((p >= 0) ? 64'sd1073741824 : (64'sd1 - 64'sd1073741824))) / 64'sd2147483648;
    e = (sh < 0) ? -sh : 0;
    mag = (h < 0) ? -h : h;
    r = (e == 0) ? mag : (mag + (64'sd1 << (e - 1))) / (64'sd1 << e);
    if (h < 0) r = -r;
    y = int'(r) + off;
    if (y < amin) y = amin;
    else if (y > amax) y = amax;
    return 8'(y);
  endfunction

  function automatic logic [31:0] model_word(input logic [127:0] accs);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++)
      w[8*j +: 8] = ref_byte(int'(accs[32*j +: 32]), int'(bias_i[32*j +: 32]), int'(multiplier_i),
                             int'($signed(shift_i)), int'(out_offset_i),
                             int'($signed(act_min_i)), int'($signed(act_max_i)));
    return w;
  endfunction

  function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  task automatic set_cfg(input int m, input int sh, input int off, input int mn, input int mx);
    multiplier_i = 32'(m);
    shift_i      = 6'(sh);
    out_offset_i = 32'(off);
    act_min_i    = 8'(mn);
    act_max_i    = 8'(mx);
  endtask

  // Consumer backpressure: hold ready low for stall_left cycles on stall_row.
  initial forever begin
    @(posedge clk); #1;
    if (stall_left > 0 && o_if.out_valid && words_seen == stall_row) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && t_start >= 0) begin
      int rel;
      rel = cyc - t_start + 1;
      if (o_if.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(o_if.out_valid), 32'd0);
        end else begin
          chk($sformatf("row%0d_data", words_seen), o_if.out_data, exp_q[0]);
          if (first_valid_rel < 0) first_valid_rel = rel;
          if (!out_ready) stall_seen++;
          if (out_ready) begin
            $display("word %0d accepted: 0x%08h (cycle T+%0d)", words_seen, o_if.out_data, rel);
            last_word = o_if.out_data;
            void'(exp_q.pop_front());
            words_seen++;
          end
        end
      end
      if ((rel == 1 || hs_prev) && busy_o && !done_o) idx_log.push_back(int'(C_index_o));
      hs_prev = o_if.out_valid && out_ready;
      if (done_o) begin
        done_cnt++;
        done_rel = rel;
      end
      if (busy_prev && !busy_o && busy_fall_rel < 0) busy_fall_rel = rel;
      busy_prev = busy_o;
    end
  end

  task automatic begin_drain(input int nrows, input int s_row, input int s_len);
    int n;
    n = (nrows > 4) ? 4 : nrows;
    for (int r = 0; r < n; r++) exp_q.push_back(model_word(cbuf[r]));
    words_seen = 0; done_cnt = 0; stall_seen = 0;
    first_valid_rel = -1; done_rel = -1; busy_fall_rel = -1;
    idx_log.delete();
    stall_row = s_row;
    stall_left = s_len;
    rows_i = 3'(nrows);
    @(posedge clk); #1;
    start_i = 1'b1;
    t_start = cyc + 1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic run_drain(input int nrows, input int s_row, input int s_len, input bit mid_start);
    int n;
    n = (nrows > 4) ? 4 : nrows;
    begin_drain(nrows, s_row, s_len);
    for (int k = 0; k < 200 && busy_fall_rel < 0; k++) begin
      if (mid_start && k == 6) begin
        start_i = 1'b1;
        rows_i  = 3'd1;
        bias_i  = ~bias_i;
      end else if (mid_start && k == 7) begin
        start_i = 1'b0;
      end
      @(posedge clk); #1;
    end
    if (busy_fall_rel < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: busy still %0d after 200 cycles, required 0", busy_o);
    end
    chk("word_count", 32'(words_seen), 32'(n));
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("leftover_expected", 32'(exp_q.size()), 32'd0);
    chk("busy_fall", 32'(busy_fall_rel), 32'(done_rel + 1));
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 4; r++) cbuf[r] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_valid", 32'(o_if.out_valid), 32'd0);
    chk("rst_index", 32'(C_index_o), 32'd0);
    chk("rst_data", o_if.out_data, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic drain: 100 * 0.5 = 50, minus 128 -> -78.
    cbuf[0] = pack4(100, 100, 100, 100);
    bias_i = '0;
    set_cfg(1 << 30, 0, -128, -128, 127);
    chk("model_basic", model_word(cbuf[0]), 32'hB2B2B2B2);
    run_drain(1, 0, 0, 0);
    chk("basic_valid_cycle", 32'(first_valid_rel), 32'd5);
    chk("basic_done_cycle", 32'(done_rel), 32'd6);
    chk("basic_word", last_word, 32'hB2B2B2B2);

    // Negative shift: h = {50,-1,0,1}; halves round away from zero -> {25,-1,0,1}.
    cbuf[0] = pack4(100, -3, 0, 2);
    set_cfg(1 << 30, -1, 0, -128, 127);
    chk("model_negshift", model_word(cbuf[0]), 32'h0100FF19);
    run_drain(1, 0, 0, 0);
    chk("negshift_word", last_word, 32'h0100FF19);

    cbuf[0] = pack4(1000000, 1000000, 1000000, 1000000);
    set_cfg(32'h7FFF_FFFF, 0, 0, -128, 127);
    chk("model_sat_a", model_word(cbuf[0]), 32'h7F7F7F7F);
    run_drain(1, 0, 0, 0);
    chk("sat_a_word", last_word, 32'h7F7F7F7F);

    cbuf[0] = pack4(INT_MIN, INT_MIN, INT_MIN, INT_MIN);
    set_cfg(INT_MIN, 0, 0, -128, 127);
    chk("model_sat_b", model_word(cbuf[0]), 32'h7F7F7F7F);
    run_drain(1, 0, 0, 0);
    chk("sat_b_word", last_word, 32'h7F7F7F7F);

    cbuf[0] = pack4(100, 100, 100, 100);
    set_cfg(1 << 30, 0, 0, 0, 6);
    chk("model_sat_c", model_word(cbuf[0]), 32'h06060606);
    run_drain(1, 0, 0, 0);
    chk("sat_c_word", last_word, 32'h06060606);

    // Four distinct rows, 3-cycle stall on row 1, ignored start mid-drain.
    for (int r = 0; r < 4; r++)
      cbuf[r] = pack4(r * 700 - 900, 250 - r * 333, r * r * 150 + 7, -50 * r - 1);
    bias_i = pack4(10, -20, 300, -4000);
    set_cfg(1518500250, -3, 5, -100, 100);
    run_drain(4, 1, 3, 1);
    chk("index_count", 32'(idx_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < idx_log.size(); i++)
      chk($sformatf("index_seq%0d", i), 32'(idx_log[i]), 32'(i));
    chk("stall_cycles", 32'(stall_seen), 32'd3);

    run_drain(0, 0, 0, 0);
    chk("rows0_done_cycle", 32'(done_rel), 32'd1);
    chk("rows0_no_valid", 32'(first_valid_rel), 32'hFFFF_FFFF);

    for (int r = 0; r < 4; r++)
      cbuf[r] = pack4(r * 11 + 5, -r * 13 - 7, 40 - r * 9, r * 17 - 30);
    bias_i = pack4(1, -2, 3, -4);
    set_cfg(1 << 29, 2, -3, -128, 127);
    run_drain(7, 0, 0, 0);

    // Reset during P2 of row 1, then a clean drain from row 0.
    for (int r = 0; r < 4; r++)
      cbuf[r] = pack4(r * 40 + 9, -r * 25 - 3, 77 - r, r * 5);
    bias_i = pack4(0, 4, -4, 8);
    set_cfg(1 << 30, 0, 0, -128, 127);
    begin_drain(2, 0, 0);
    repeat (7) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_words", 32'(words_seen), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_valid", 32'(o_if.out_valid), 32'd0);
    chk("midrst_index", 32'(C_index_o), 32'd0);
    chk("midrst_data", o_if.out_data, 32'd0);
    exp_q.delete();
    busy_prev = 0;
    hs_prev = 0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run_drain(2, 0, 0, 0);
    chk("post_reset_index_first", (idx_log.size() > 0) ? 32'(idx_log[0]) : 32'hFFFF_FFFF, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
